// File: rtl/irq_debouncer.sv
// Interrupt pin debouncer: a synchronizer, then a four-state qualification FSM.
// It produces a clean level, rise/fall pulses and a saturating count of rejected pulses.
module irq_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned ACTIVE_LOW_IN   = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       irq_raw_i,
  output logic       irq_debounced_o,
  output logic       irq_rise_o,
  output logic       irq_fall_o,
  input  logic       glitch_clr_i,
  output logic [7:0] glitch_cnt_bo
);

  typedef enum logic [1:0] {StStableLo, StQualHi, StStableHi, StQualLo} state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic                   pin_norm;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   glitch;
  logic                   deb_d;
  logic                   rise_q, rise_d, fall_q, fall_d;
  logic [7:0]             glitch_cnt_q;

  // Normalise polarity before the synchronizer so reset value 0 always means inactive.
  assign pin_norm = irq_raw_i ^ (ACTIVE_LOW_IN != 0);
  assign s        = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_norm};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    glitch  = 1'b0;
    unique case (state_q)
      StStableLo: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = StStableHi;
          end else begin
            state_d = StQualHi;
            cnt_d   = CntOne;
          end
        end
      end
      StQualHi: begin
        if (s) begin
          if (cnt_q == CntMax) begin
            state_d = StStableHi;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          state_d = StStableLo;
          glitch  = 1'b1;
        end
      end
      StStableHi: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = StStableLo;
          end else begin
            state_d = StQualLo;
            cnt_d   = CntOne;
          end
        end
      end
      StQualLo: begin
        if (!s) begin
          if (cnt_q == CntMax) begin
            state_d = StStableLo;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          state_d = StStableHi;
          glitch  = 1'b1;
        end
      end
      default: state_d = StStableLo;
    endcase
  end

  // Pulses are registered alongside the state so they coincide with the new level.
  always_comb begin
    deb_d  = (state_d == StStableHi) || (state_d == StQualLo);
    rise_d = deb_d & ~irq_debounced_o;
    fall_d = ~deb_d & irq_debounced_o;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StStableLo;
      cnt_q        <= '0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      glitch_cnt_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      if (glitch_clr_i) begin
        glitch_cnt_q <= 8'h00;
      end else if (glitch && (glitch_cnt_q != 8'hFF)) begin
        glitch_cnt_q <= glitch_cnt_q + 8'h01;
      end
    end
  end

  assign irq_debounced_o = (state_q == StStableHi) || (state_q == StQualLo);
  assign irq_rise_o      = rise_q;
  assign irq_fall_o      = fall_q;
  assign glitch_cnt_bo   = glitch_cnt_q;

endmodule

// File: tb/tb_irq_debouncer.sv
// Bench for irq_debouncer: directed and random pin activity compared each cycle
// against a run-length reference model of the qualification rules.
module tb_irq_debouncer;

  localparam int unsigned Sync = 2;
  localparam int unsigned Deb  = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       irq_raw_i;
  logic       glitch_clr_i;
  logic       irq_debounced_o, irq_rise_o, irq_fall_o;
  logic [7:0] glitch_cnt_bo;
  logic       raw_al;
  logic       deb_al, rise_al, fall_al;
  logic [7:0] gcnt_al;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic pipe [Sync];
  logic m_level, m_rise, m_fall;
  int   m_run, m_gcnt;

  always #5 clk_i = ~clk_i;

  irq_debouncer #(
    .SYNC_STAGES(Sync), .DEBOUNCE_CYCLES(Deb), .CNT_WIDTH(16), .ACTIVE_LOW_IN(0)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_raw_i(irq_raw_i),
    .irq_debounced_o(irq_debounced_o), .irq_rise_o(irq_rise_o), .irq_fall_o(irq_fall_o),
    .glitch_clr_i(glitch_clr_i), .glitch_cnt_bo(glitch_cnt_bo)
  );

  irq_debouncer #(
    .SYNC_STAGES(Sync), .DEBOUNCE_CYCLES(Deb), .CNT_WIDTH(16), .ACTIVE_LOW_IN(1)
  ) u_dut_al (
    .clk_i(clk_i), .rst_i(rst_i), .irq_raw_i(raw_al),
    .irq_debounced_o(deb_al), .irq_rise_o(rise_al), .irq_fall_o(fall_al),
    .glitch_clr_i(glitch_clr_i), .glitch_cnt_bo(gcnt_al)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < Sync; i++) pipe[i] = 1'b0;
    m_level = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_run   = 0;
    m_gcnt  = 0;
  endtask

  // Output flips once the sample has disagreed with it for Deb cycles in a row;
  // a disagreement run that ends early is one glitch.
  task automatic model_edge();
    logic s;
    if (!rst_i) begin
      model_reset();
      return;
    end
    s = pipe[Sync-1];
    for (int i = Sync - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = irq_raw_i;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (m_run == Deb) begin
        m_level = s;
        m_run   = 0;
        m_rise  = s;
        m_fall  = ~s;
      end
    end else begin
      if (m_run > 0 && m_gcnt < 255) m_gcnt++;
      m_run = 0;
    end
    if (glitch_clr_i) m_gcnt = 0;
  endtask

  task automatic check_all();
    check("debounced", 8'(irq_debounced_o), 8'(m_level));
    check("rise", 8'(irq_rise_o), 8'(m_rise));
    check("fall", 8'(irq_fall_o), 8'(m_fall));
    check("glitch_cnt", glitch_cnt_bo, 8'(m_gcnt));
    check("rise_fall_excl", 8'(irq_rise_o & irq_fall_o), 8'h00);
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
    @(negedge clk_i);
  endtask

  initial begin
    int lat;
    rst_i        = 1'b0;
    irq_raw_i    = 1'b0;
    glitch_clr_i = 1'b0;
    raw_al       = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_i);
    check("rst_deb", 8'(irq_debounced_o), 8'h00);
    check("rst_rise", 8'(irq_rise_o), 8'h00);
    check("rst_fall", 8'(irq_fall_o), 8'h00);
    check("rst_gcnt", glitch_cnt_bo, 8'h00);
    check("rst_deb_al", 8'(deb_al), 8'h00);
    rst_i = 1'b1;
    repeat (4) step();

    // Clean rise: pulse expected on the 6th edge after the pin change.
    irq_raw_i = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (irq_rise_o && lat == 0) lat = i;
    end
    check("rise_latency", 8'(lat), 8'd6);
    check("rise_gcnt", glitch_cnt_bo, 8'h00);

    // Clean fall.
    irq_raw_i = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (irq_fall_o && lat == 0) lat = i;
    end
    check("fall_latency", 8'(lat), 8'd6);

    // Bounce: three high cycles are rejected.
    irq_raw_i = 1'b1;
    repeat (3) step();
    irq_raw_i = 1'b0;
    repeat (8) step();
    check("bounce_deb", 8'(irq_debounced_o), 8'h00);
    check("bounce_gcnt", glitch_cnt_bo, 8'h01);

    // Random pin activity with occasional clears.
    for (int r = 0; r < 60; r++) begin
      irq_raw_i = 1'($urandom_range(0, 1));
      for (int k = 0; k < int'($urandom_range(1, 9)); k++) begin
        glitch_clr_i = ($urandom_range(0, 15) == 0);
        step();
      end
    end
    glitch_clr_i = 1'b0;
    irq_raw_i = 1'b0;
    repeat (10) step();

    // Saturation, then a clear landing on the same edge as a glitch.
    for (int p = 0; p < 300; p++) begin
      irq_raw_i = 1'b1;
      repeat (3) step();
      irq_raw_i = 1'b0;
      repeat (3) step();
    end
    check("sat_gcnt", glitch_cnt_bo, 8'hFF);
    irq_raw_i = 1'b1;
    repeat (3) step();
    irq_raw_i = 1'b0;
    repeat (2) step();
    glitch_clr_i = 1'b1;
    step();
    glitch_clr_i = 1'b0;
    check("clr_wins", glitch_cnt_bo, 8'h00);
    repeat (3) step();

    // Reset asserted mid-qualification (counter at 2).
    irq_raw_i = 1'b1;
    repeat (4) step();
    rst_i     = 1'b0;
    irq_raw_i = 1'b0;
    #1;
    model_reset();
    check("midq_deb", 8'(irq_debounced_o), 8'h00);
    check("midq_rise", 8'(irq_rise_o), 8'h00);
    check("midq_gcnt", glitch_cnt_bo, 8'h00);
    @(negedge clk_i);
    repeat (2) step();
    rst_i = 1'b1;
    repeat (10) step();

    // Pin already active at reset release qualifies as a normal rise.
    rst_i     = 1'b0;
    irq_raw_i = 1'b1;
    repeat (2) step();
    rst_i = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (irq_rise_o && lat == 0) lat = i;
    end
    check("release_rise_latency", 8'(lat), 8'd6);
    irq_raw_i = 1'b0;
    repeat (10) step();

    // Active-low pin instance.
    raw_al = 1'b0;
    repeat (5) step();
    check("al_before", 8'(deb_al), 8'h00);
    step();
    check("al_after", 8'(deb_al), 8'h01);
    check("al_rise", 8'(rise_al), 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
